// File: rtl/pool1_buf_sched.sv
// pool1_buf_sched: schedules pool1 write bursts into the MEM_HEIGHT-row ring and conv2 read passes.
// Define POOL1_SCHED_PERF_EN to build the producer stall counter; otherwise stall_cnt is tied to 0.

module pool1_buf_sched #(
    parameter int unsigned LENGTH     = 48,
    parameter int unsigned HEIGHT     = 126,
    parameter int unsigned MEM_HEIGHT = 6,
    parameter int unsigned FILTER     = 5,
    parameter int unsigned STRIDE     = 2,
    parameter int unsigned STRIDE_IN  = 2,
    parameter int unsigned CH_PAR     = 4,
    parameter int unsigned CW         = 8
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_start,
    output logic          wr_busy,
    output logic          rd_start,
    input  logic          rd_done,
    output logic [CW-1:0] rd_row,
    output logic          frame_done,
    output logic          err,
    output logic [15:0]   stall_cnt
);

    localparam int unsigned BEAT_W = (CH_PAR > 1) ? $clog2(CH_PAR) : 1;
    localparam int unsigned XW     = CW + 1;

    typedef enum logic       {F_IDLE, F_RUN} f_state_t;
    typedef enum logic [1:0] {W_IDLE, W_START, W_BEAT, W_GAP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} r_state_t;

    f_state_t          f_state;
    w_state_t          w_state;
    r_state_t          r_state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [CW-1:0]     wr_col;
    logic [CW-1:0]     wr_row;
    logic [CW-1:0]     rows_written;
    logic [CW-1:0]     rd_base;

    logic [XW-1:0]     room_c;
    logic [XW-1:0]     rd_end_c;
    logic [CW-1:0]     rd_base_nxt_c;
    logic              rd_last_c;
    logic              rd_elig_c;

    // Ring-space and pass-eligibility decisions use registered counters only.
    assign room_c        = {1'b0, wr_row} + XW'(STRIDE_IN) - {1'b0, rd_base};
    assign rd_end_c      = {1'b0, rd_base} + XW'(FILTER);
    assign rd_base_nxt_c = rd_base + CW'(STRIDE);
    assign rd_last_c     = ({1'b0, rd_base_nxt_c} + XW'(FILTER)) > XW'(HEIGHT);
    assign rd_elig_c     = (f_state == F_RUN) && (r_state == R_IDLE)
                         && (rd_end_c <= XW'(HEIGHT))
                         && ({1'b0, rows_written} >= rd_end_c);

    assign in_ready = (f_state == F_RUN) && (w_state == W_IDLE)
                    && (wr_row < CW'(HEIGHT))
                    && (room_c <= XW'(MEM_HEIGHT));
    assign rd_row   = rd_base;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            f_state      <= F_IDLE;
            w_state      <= W_IDLE;
            r_state      <= R_IDLE;
            beat_cnt     <= '0;
            wr_col       <= '0;
            wr_row       <= '0;
            rows_written <= '0;
            rd_base      <= '0;
            wr_start     <= 1'b0;
            wr_busy      <= 1'b0;
            rd_start     <= 1'b0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            wr_start   <= 1'b0;
            rd_start   <= 1'b0;
            frame_done <= 1'b0;

            // Write burst: start pulse, CH_PAR beats, one idle gap cycle.
            case (w_state)
                W_IDLE: begin
                    if (in_valid && in_ready) begin
                        w_state  <= W_START;
                        wr_start <= 1'b1;
                    end
                end
                W_START: begin
                    w_state  <= W_BEAT;
                    wr_busy  <= 1'b1;
                    beat_cnt <= '0;
                end
                W_BEAT: begin
                    if (beat_cnt == BEAT_W'(CH_PAR - 1)) begin
                        w_state <= W_GAP;
                        wr_busy <= 1'b0;
                        if (wr_col > CW'(LENGTH - STRIDE_IN - 1)) begin
                            wr_col       <= '0;
                            wr_row       <= wr_row + CW'(STRIDE_IN);
                            rows_written <= rows_written + CW'(STRIDE_IN);
                        end else begin
                            wr_col <= wr_col + CW'(STRIDE_IN);
                        end
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                W_GAP:   w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase

            // Read pass: issue, then wait for conv2 to release the window.
            case (r_state)
                R_IDLE: begin
                    if (rd_elig_c) begin
                        r_state  <= R_ISSUE;
                        rd_start <= 1'b1;
                    end
                end
                R_ISSUE: r_state <= R_WAIT;
                R_WAIT: begin
                    if (rd_done) begin
                        r_state <= R_IDLE;
                        rd_base <= rd_base_nxt_c;
                        if (rd_last_c) begin
                            frame_done <= 1'b1;
                            f_state    <= F_IDLE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase

            if (rd_done && (r_state != R_WAIT)) begin
                err <= 1'b1;
            end

            // Frame arming; a restart attempt while running is a protocol error.
            if (frame_start) begin
                if (f_state == F_IDLE) begin
                    f_state      <= F_RUN;
                    wr_col       <= '0;
                    wr_row       <= '0;
                    rows_written <= '0;
                    rd_base      <= '0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef POOL1_SCHED_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of cycles the producer waits while a frame runs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (frame_start && (f_state == F_IDLE)) begin
            stall_q <= '0;
        end else if ((f_state == F_RUN) && in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/pool1_buf_sched.md
Name: pool1_buf_sched

Overview:
- Sequences the pool1 output line buffer. It schedules channel-group write bursts from the pool1 stage into the MEM_HEIGHT-row ring buffer.
- It releases conv2 window read passes, one output row per pass.
- It holds a row-credit count so the writer never overwrites ring rows that an unfinished read pass still needs.
- Sits between the pool1 pixel producer, the line buffer's start/write port, and the conv2 read engine.

Parameters:
- LENGTH, 48, pixels per input row
- HEIGHT, 126, rows per frame
- MEM_HEIGHT, 6, ring buffer depth in rows
- FILTER, 5, conv2 window height in rows
- STRIDE, 2, conv2 row step per read pass
- STRIDE_IN, 2, rows and columns covered by one write group
- CH_PAR, 4, write beats per pixel group (one beat per 64-bit channel slice)
- CW, 8, width of row and column counters

Ports:
- clk_in  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; arms a new frame
- in_valid  in  1  pool1 holds a pixel group
- in_ready  out  1  group accepted this cycle when in_valid & in_ready
- wr_start  out  1  one-cycle pulse that starts a CH_PAR-beat buffer write
- wr_busy  out  1  high during beat cycles
- rd_start  out  1  one-cycle pulse that starts one conv2 read pass
- rd_done  in  1  conv2 has finished the current pass
- rd_row  out  CW  first input row of the current or next pass
- frame_done  out  1  one-cycle pulse after the last pass completes
- err  out  1  sticky protocol error
- stall_cnt  out  16  producer stall counter (see Optional Feature)

Behaviour:
- Reset (async) clears every register.
  - Outputs: in_ready, wr_start, wr_busy, rd_start, frame_done, err = 0; rd_row = 0; stall_cnt = 0.
  - All FSMs go to idle.
  - Reset mid-frame abandons the frame with no frame_done.
- Frame FSM F_IDLE/F_RUN.
  - In F_IDLE, frame_start clears wr_col, wr_row, rows_written and rd_base, then moves to F_RUN.
  - frame_start while in F_RUN sets err and is otherwise ignored.
- Write FSM W_IDLE -> W_START -> W_BEAT -> W_GAP -> W_IDLE.
  - in_ready = F_RUN & W_IDLE & (wr_row < HEIGHT) & (wr_row + STRIDE_IN - rd_base <= MEM_HEIGHT).
  - Accept moves to W_START.
  - W_START drives wr_start = 1 for exactly 1 cycle.
  - W_BEAT lasts CH_PAR cycles with wr_busy = 1.
  - W_GAP is 1 cycle with start low, guaranteeing a fresh rising edge for the buffer.
  - Minimum group period: CH_PAR + 3 = 7 cycles.
- On leaving W_BEAT:
  - If wr_col > LENGTH - STRIDE_IN - 1: wr_col = 0, wr_row += STRIDE_IN, rows_written += STRIDE_IN.
  - Otherwise wr_col += STRIDE_IN.
- Read FSM R_IDLE -> R_ISSUE -> R_WAIT.
  - Pass eligible when F_RUN & R_IDLE & (rd_base + FILTER <= HEIGHT) & (rows_written >= rd_base + FILTER).
  - R_ISSUE pulses rd_start for 1 cycle, with rd_row = rd_base.
  - R_WAIT holds until rd_done, then rd_base += STRIDE and the FSM returns to R_IDLE.
- rd_done outside R_WAIT sets err and is otherwise ignored.
- End of frame: after an rd_done that leaves rd_base + FILTER > HEIGHT, frame_done = 1 for one cycle and the block returns to F_IDLE.
  - Defaults give 61 passes and 63 row-pair writes.
- Simultaneous events: a row-end update and rd_done in the same cycle both apply. in_ready and pass eligibility use the registered values from the next cycle; no combinational bypass.
- Arithmetic: CW-bit unsigned. The comparison wr_row + STRIDE_IN - rd_base is evaluated at CW+1 bits; invariant wr_row >= rd_base.
- Latency: accept -> wr_start is 1 cycle. Eligibility -> rd_start is 1 cycle.

Optional Feature:
- Macro: POOL1_SCHED_PERF_EN.
- Defined: stall_cnt increments each F_RUN cycle with in_valid & !in_ready. It saturates at 16'hFFFF and clears on frame_start.
- Undefined: no counter logic; stall_cnt is tied to 0.

Test Plan:
- Reset then frame_start, in_valid held high -> wr_start pulses every 7 cycles; in_ready drops after rows_written = 6 (72 groups); first rd_start with rd_row = 0 only after row-pair 2 completes.
- Hold rd_done low after pass 0 -> in_ready stays 0 with wr_row = 6 and rd_base = 0; pulse rd_done -> rd_base = 2, and in_ready = 1 on the next cycle.
- Full frame with rd_done 10 cycles after each rd_start -> exactly 61 rd_start pulses, last rd_row = 120, one frame_done, err = 0.
- rd_done pulsed in R_IDLE, and frame_start pulsed mid-frame -> err = 1 and stays set; counters unchanged.
- Last write-group row-end in the same cycle as rd_done -> rows_written and rd_base both update; no lost credit and no extra pass.
- Assert rst_n low mid-burst (wr_busy = 1) -> all outputs 0 immediately. With POOL1_SCHED_PERF_EN, stall_cnt = 0; a new frame runs correctly.
